serial_wide_adder: RTL and testbench

SERIAL_WIDE_ADDER -- requirements
Module: serial_wide_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_wide_adder_if.sv | 14 +
 rtl/serial_wide_adder_bk8.sv | 34 +++
 rtl/serial_wide_adder.sv | 79 +++++++
 tb/tb_serial_wide_adder.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and byte width for the serial wide adder
package serial_adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_wide_adder_if.sv
// serial_wide_adder_if: request/result bundle between a requester and the serial adder
interface serial_wide_adder_if #(parameter int NBYTES = 4) ();

    logic                  start;
    logic [8*NBYTES-1:0]   A;
    logic [8*NBYTES-1:0]   B;
    logic                  busy;
    logic                  done;
    logic [8*NBYTES:0]     S;

    modport master (output start, A, B, input busy, done, S);
    modport slave  (input start, A, B, output busy, done, S);

endinterface

// File: rtl/serial_wide_adder_bk8.sv
// BrentKung8b: 8-bit Brent-Kung prefix adder, S[8] is the carry-out
module BrentKung8b (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [8:0] S
);

    logic [7:0] g, p, c;
    logic g32, p32, g54, p54, g76, p76, g74, p74;

    assign g = A & B;
    assign p = A ^ B;

    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g54 = g[5] | (p[5] & g[4]);
    assign p54 = p[5] & p[4];
    assign g76 = g[7] | (p[7] & g[6]);
    assign p76 = p[7] & p[6];
    assign g74 = g76 | (p76 & g54);
    assign p74 = p76 & p54;

    assign c[0] = g[0];
    assign c[1] = g[1] | (p[1] & g[0]);
    assign c[3] = g32 | (p32 & c[1]);
    assign c[7] = g74 | (p74 & c[3]);
    assign c[5] = g54 | (p54 & c[3]);
    assign c[2] = g[2] | (p[2] & c[1]);
    assign c[4] = g[4] | (p[4] & c[3]);
    assign c[6] = g[6] | (p[6] & c[5]);

    assign S = {c[7], p[7:1] ^ c[6:0], p[0]};

endmodule

// File: rtl/serial_wide_adder.sv
// serial_wide_adder: adds two NBYTES-wide operands one byte per cycle, LSB first
module serial_wide_adder
    import serial_adder_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_wide_adder_if.slave bus
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W:0]      s_q, s_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [8:0]      sum0, sum1;

    BrentKung8b u_add_ab (.A(a_q[BYTE_W-1:0]), .B(b_q[BYTE_W-1:0]), .S(sum0));
    BrentKung8b u_add_ci (.A(sum0[BYTE_W-1:0]), .B({7'b0, carry_q}), .S(sum1));

    // one byte per RUN cycle; start is only honoured outside RUN
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (state_q == RUN) begin
            a_d = a_q >> BYTE_W;
            b_d = b_q >> BYTE_W;
            s_d[BYTE_W*int'(cnt_q) +: BYTE_W] = sum1[BYTE_W-1:0];
            carry_d = sum0[8] | sum1[8];
            if (cnt_q == CW'(NBYTES - 1)) begin
                s_d[W]  = carry_d;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (state_q == DONE) state_d = IDLE;
            if (bus.start) begin
                a_d     = bus.A;
                b_d     = bus.B;
                carry_d = 1'b0;
                cnt_d   = '0;
                state_d = RUN;
            end
        end
    end

    // state and datapath registers, reset wins over any start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.S    = s_q;

endmodule

// File: tb/tb_serial_wide_adder.sv
// tb_serial_wide_adder: directed self-checking bench for serial_wide_adder with NBYTES=4
module tb_serial_wide_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    serial_wide_adder_if #(.NBYTES(4)) bus ();

    serial_wide_adder #(.NBYTES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // start one op, scramble operands during RUN, wait for done; returns S, cycles to done, busy cycles
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [32:0] s, output int lat, output int nbusy, output bit ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = ~a;
        bus.B = a ^ b;
        lat = 0;
        nbusy = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        s = bus.S;
        @(negedge clk);
        check("done_one_cycle", {63'b0, bus.done}, 64'd0);
    endtask

    logic [32:0] s;
    int lat, nbusy, ndone;
    bit ok;
    logic [31:0] va [4] = '{32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_FFFF};
    logic [31:0] vb [4] = '{32'h0000_0002, 32'h8000_0000, 32'h1111_1111, 32'h0000_0001};
    logic [32:0] vs [4] = '{33'h0_0000_0003, 33'h1_0000_0000, 33'h0_EFBE_D000, 33'h0_0001_0000};

    initial begin
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_done", {63'b0, bus.done}, 64'd0);
        check("rst_s", {31'b0, bus.S}, 64'd0);
        bus.start = 1'b1;
        bus.A = 32'h1234_5678;
        @(negedge clk);
        check("rst_beats_start", {63'b0, bus.busy}, 64'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        do_op(32'hFFFF_FFFF, 32'h0000_0001, s, lat, nbusy, ok);
        check("carry_ripple_ok", {63'b0, ok}, 64'd1);
        check("carry_ripple_s", {31'b0, s}, 64'h1_0000_0000);
        check("carry_ripple_lat", 64'(lat), 64'd4);
        check("carry_ripple_busy", 64'(nbusy), 64'd4);

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, s, lat, nbusy, ok);
        check("all_ones_s", {31'b0, s}, 64'h1_FFFF_FFFE);

        do_op(32'h0, 32'h0, s, lat, nbusy, ok);
        check("zero_ok", {63'b0, ok}, 64'd1);
        check("zero_s", {31'b0, s}, 64'd0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 32'h0000_00FF;
        bus.B = 32'h0000_0001;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 32'h5555_5555;
        bus.B = 32'h5555_5555;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        s = '0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) begin
                ndone++;
                s = bus.S;
            end
            @(negedge clk);
        end
        check("ignore_start_ndone", 64'(ndone), 64'd1);
        check("ignore_start_s", {31'b0, s}, 64'h0_0000_0100);

        bus.start = 1'b1;
        bus.A = 32'hFFFF_FFFF;
        bus.B = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {63'b0, bus.busy}, 64'd0);
        check("abort_s", {31'b0, bus.S}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        do_op(32'h1234_5678, 32'h0F0F_0F0F, s, lat, nbusy, ok);
        check("after_abort_s", {31'b0, s}, 64'h0_2143_6587);

        begin
            int idx, cyc, last;
            idx = 0;
            cyc = 0;
            last = 0;
            bus.start = 1'b1;
            bus.A = va[0];
            bus.B = vb[0];
            while (idx < 4 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (bus.done) begin
                    check($sformatf("b2b_s%0d", idx), {31'b0, bus.S}, {31'b0, vs[idx]});
                    if (idx > 0) check($sformatf("b2b_gap%0d", idx), 64'(cyc - last), 64'd5);
                    last = cyc;
                    idx++;
                    if (idx < 4) begin
                        bus.A = va[idx];
                        bus.B = vb[idx];
                    end else begin
                        bus.start = 1'b0;
                    end
                end else begin
                    bus.A = 32'hA5A5_A5A5 ^ 32'(cyc);
                    bus.B = 32'h5A5A_5A5A;
                end
            end
            bus.start = 1'b0;
            check("b2b_count", 64'(idx), 64'd4);
        end
        @(negedge clk);

        begin
            int bad;
            logic [31:0] ra, rb;
            bad = 0;
            for (int i = 0; i < 200; i++) begin
                ra = $urandom;
                rb = $urandom;
                do_op(ra, rb, s, lat, nbusy, ok);
                if (!ok || s !== ({1'b0, ra} + {1'b0, rb})) begin
                    bad++;
                    $display("FAIL rand_sum: a=%h b=%h got %h expected %h", ra, rb, s, {1'b0, ra} + {1'b0, rb});
                end
            end
            check("rand_errors", 64'(bad), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
